// File: rtl/vid_if.sv
// Video source bundle: generator controls in, timing/pixel/status out.
//   i_en, i_mode, i_solid_rgb      : enable, pattern select, solid colour
//   o_vid_data/hsync/vsync/VDE     : pixel stream consumed by colour_change
//   o_hcnt, o_vcnt                 : position carried by the current output
//   o_frame_cnt, o_sof             : completed frames, start-of-frame pulse
interface vid_if;
  logic        i_en;
  logic [1:0]  i_mode;
  logic [23:0] i_solid_rgb;
  logic [23:0] o_vid_data;
  logic        o_vid_hsync;
  logic        o_vid_vsync;
  logic        o_vid_VDE;
  logic [11:0] o_hcnt;
  logic [10:0] o_vcnt;
  logic [7:0]  o_frame_cnt;
  logic        o_sof;

  modport master (
    input  i_en, i_mode, i_solid_rgb,
    output o_vid_data, o_vid_hsync, o_vid_vsync, o_vid_VDE,
    output o_hcnt, o_vcnt, o_frame_cnt, o_sof
  );

  modport slave (
    output i_en, i_mode, i_solid_rgb,
    input  o_vid_data, o_vid_hsync, o_vid_vsync, o_vid_VDE,
    input  o_hcnt, o_vcnt, o_frame_cnt, o_sof
  );
endinterface

// File: rtl/vid_timing_gen.sv
// 1080p-style video timing and test-pattern generator.
//   clk : pixel clock
//   rst : synchronous active-high reset
//   vid : vid_if.master (controls in, registered video/status out)
// Every output in cycle n describes the counter position of cycle n-1.
module vid_timing_gen #(
  parameter int unsigned H_ACTIVE = 1920,
  parameter int unsigned H_FP     = 88,
  parameter int unsigned H_SYNC   = 44,
  parameter int unsigned H_BP     = 148,
  parameter int unsigned V_ACTIVE = 1080,
  parameter int unsigned V_FP     = 4,
  parameter int unsigned V_SYNC   = 5,
  parameter int unsigned V_BP     = 36,
  parameter int unsigned SYNC_POL = 1,
  parameter int unsigned BAR_W    = 240
) (
  input  logic clk,
  input  logic rst,
  vid_if.master vid
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;
  localparam logic        SYNC_ON  = (SYNC_POL != 0);

  logic [11:0] hcnt, hcnt_nx;
  logic [10:0] vcnt, vcnt_nx;
  logic [7:0]  frame_cnt, frame_nx;
  logic [1:0]  mode_q, mode_nx;
  logic [23:0] solid_q, solid_nx;
  logic [11:0] bar_cnt, bar_cnt_nx;
  logic [2:0]  bar_idx, bar_idx_nx;

  logic        at_origin, h_last, v_last, bar_last;
  logic [1:0]  eff_mode;
  logic [23:0] eff_solid;
  logic        vde_c, hs_c, vs_c;
  logic [7:0]  grey_c;
  logic [23:0] pix_c, data_c;

  assign at_origin = (hcnt == 12'd0) && (vcnt == 11'd0);
  assign h_last    = (hcnt == 12'(H_TOTAL - 1));
  assign v_last    = (vcnt == 11'(V_TOTAL - 1));
  assign bar_last  = (bar_cnt == 12'(BAR_W - 1));

  // The origin pixel already belongs to the newly latched frame settings.
  assign eff_mode  = at_origin ? vid.i_mode : mode_q;
  assign eff_solid = at_origin ? vid.i_solid_rgb : solid_q;

  // Timing decode of the current counter position.
  assign vde_c  = (hcnt < 12'(H_ACTIVE)) && (vcnt < 11'(V_ACTIVE));
  assign hs_c   = ((hcnt >= 12'(HS_START)) && (hcnt < 12'(HS_END))) ? SYNC_ON : ~SYNC_ON;
  assign vs_c   = ((vcnt >= 11'(VS_START)) && (vcnt < 11'(VS_END))) ? SYNC_ON : ~SYNC_ON;
  assign grey_c = hcnt[7:0] + frame_cnt;

  // Pattern select.
  always_comb begin : pixel
    pix_c = 24'h000000;
    case (eff_mode)
      2'd0: begin
        case (bar_idx)
          3'd0:    pix_c = 24'hFFFFFF;
          3'd1:    pix_c = 24'hFFFF00;
          3'd2:    pix_c = 24'h00FFFF;
          3'd3:    pix_c = 24'h00FF00;
          3'd4:    pix_c = 24'hFF00FF;
          3'd5:    pix_c = 24'hFF0000;
          3'd6:    pix_c = 24'h0000FF;
          default: pix_c = 24'h000000;
        endcase
      end
      2'd1:    pix_c = {grey_c, grey_c, grey_c};
      2'd2:    pix_c = (hcnt[5] ^ vcnt[5]) ? 24'hFFFFFF : 24'h000000;
      default: pix_c = eff_solid;
    endcase
  end

  assign data_c = vde_c ? pix_c : 24'h000000;

  // Counter, bar tracker and frame-latch next state.
  always_comb begin : next_state
    hcnt_nx    = hcnt;
    vcnt_nx    = vcnt;
    frame_nx   = frame_cnt;
    mode_nx    = mode_q;
    solid_nx   = solid_q;
    bar_cnt_nx = bar_cnt;
    bar_idx_nx = bar_idx;
    if (!vid.i_en) begin
      hcnt_nx    = 12'd0;
      vcnt_nx    = 11'd0;
      bar_cnt_nx = 12'd0;
      bar_idx_nx = 3'd0;
    end else begin
      if (at_origin) begin
        mode_nx  = vid.i_mode;
        solid_nx = vid.i_solid_rgb;
      end
      if (h_last) begin
        hcnt_nx    = 12'd0;
        bar_cnt_nx = 12'd0;
        bar_idx_nx = 3'd0;
        if (v_last) begin
          vcnt_nx  = 11'd0;
          frame_nx = frame_cnt + 8'd1;
        end else begin
          vcnt_nx  = vcnt + 11'd1;
        end
      end else begin
        hcnt_nx = hcnt + 12'd1;
        // Bar index advances every BAR_W pixels; beyond the active area it is don't-care.
        if (bar_last) begin
          bar_cnt_nx = 12'd0;
          bar_idx_nx = bar_idx + 3'd1;
        end else begin
          bar_cnt_nx = bar_cnt + 12'd1;
        end
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt            <= 12'd0;
      vcnt            <= 11'd0;
      frame_cnt       <= 8'd0;
      mode_q          <= 2'd0;
      solid_q         <= 24'd0;
      bar_cnt         <= 12'd0;
      bar_idx         <= 3'd0;
      vid.o_vid_data  <= 24'd0;
      vid.o_vid_hsync <= ~SYNC_ON;
      vid.o_vid_vsync <= ~SYNC_ON;
      vid.o_vid_VDE   <= 1'b0;
      vid.o_hcnt      <= 12'd0;
      vid.o_vcnt      <= 11'd0;
      vid.o_frame_cnt <= 8'd0;
      vid.o_sof       <= 1'b0;
    end else begin
      hcnt      <= hcnt_nx;
      vcnt      <= vcnt_nx;
      frame_cnt <= frame_nx;
      mode_q    <= mode_nx;
      solid_q   <= solid_nx;
      bar_cnt   <= bar_cnt_nx;
      bar_idx   <= bar_idx_nx;
      if (vid.i_en) begin
        vid.o_vid_data  <= data_c;
        vid.o_vid_hsync <= hs_c;
        vid.o_vid_vsync <= vs_c;
        vid.o_vid_VDE   <= vde_c;
        vid.o_hcnt      <= hcnt;
        vid.o_vcnt      <= vcnt;
        vid.o_frame_cnt <= frame_cnt;
        vid.o_sof       <= at_origin;
      end else begin
        vid.o_vid_data  <= 24'd0;
        vid.o_vid_hsync <= ~SYNC_ON;
        vid.o_vid_vsync <= ~SYNC_ON;
        vid.o_vid_VDE   <= 1'b0;
        vid.o_hcnt      <= 12'd0;
        vid.o_vcnt      <= 11'd0;
        vid.o_frame_cnt <= 8'd0;
        vid.o_sof       <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vid_timing_gen.sv
// Directed bench for vid_timing_gen: default geometry for line/bar checks,
// a reduced geometry (80x48) for frame, latch, enable and polarity checks,
// and a tiny geometry (11x5) to reach the frame counter wrap quickly.
module tb_vid_timing_gen;

  logic clk;
  logic rst;
  int   n_run;
  int   n_fail;

  vid_if if_a ();
  vid_if if_b ();
  vid_if if_c ();
  vid_if if_d ();

  vid_timing_gen u_a (.clk(clk), .rst(rst), .vid(if_a));

  vid_timing_gen #(
    .H_ACTIVE(64), .H_FP(4), .H_SYNC(4), .H_BP(8),
    .V_ACTIVE(40), .V_FP(2), .V_SYNC(3), .V_BP(3),
    .SYNC_POL(1), .BAR_W(8)
  ) u_b (.clk(clk), .rst(rst), .vid(if_b));

  vid_timing_gen #(
    .H_ACTIVE(64), .H_FP(4), .H_SYNC(4), .H_BP(8),
    .V_ACTIVE(40), .V_FP(2), .V_SYNC(3), .V_BP(3),
    .SYNC_POL(0), .BAR_W(8)
  ) u_c (.clk(clk), .rst(rst), .vid(if_c));

  vid_timing_gen #(
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_POL(1), .BAR_W(1)
  ) u_d (.clk(clk), .rst(rst), .vid(if_d));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [23:0] bar_col(input int idx);
    case (idx)
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  // Advance until instance B outputs position (h,v); the final position is always compared.
  task automatic wait_b(input int h, input int v);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!(if_b.o_hcnt == 12'(h) && if_b.o_vcnt == 11'(v)) && n < 10000);
    check("wait_b_pos", 32'({if_b.o_vcnt, if_b.o_hcnt}), 32'({11'(v), 12'(h)}));
  endtask

  initial begin
    int vde_n, hs_n, hs_first, pos_err, vs_n, vs_min, vs_max, sof_n, err;
    int sof_idx[3];
    logic [7:0] fc1, fc2;

    n_run = 0;
    n_fail = 0;
    rst = 1'b1;
    if_a.i_en = 1'b0; if_a.i_mode = 2'd0; if_a.i_solid_rgb = 24'd0;
    if_b.i_en = 1'b0; if_b.i_mode = 2'd0; if_b.i_solid_rgb = 24'd0;
    if_c.i_en = 1'b0; if_c.i_mode = 2'd0; if_c.i_solid_rgb = 24'd0;
    if_d.i_en = 1'b0; if_d.i_mode = 2'd0; if_d.i_solid_rgb = 24'd0;

    // Reset held for three clocks.
    repeat (3) tick();
    check("rst_vde",   if_a.o_vid_VDE, 0);
    check("rst_data",  if_a.o_vid_data, 0);
    check("rst_hs",    if_a.o_vid_hsync, 0);
    check("rst_vs",    if_a.o_vid_vsync, 0);
    check("rst_sof",   if_a.o_sof, 0);
    check("rst_hcnt",  if_a.o_hcnt, 0);
    check("rst_fc",    if_a.o_frame_cnt, 0);
    check("rst_hs_lo", if_c.o_vid_hsync, 1);
    check("rst_vs_lo", if_c.o_vid_vsync, 1);

    // Default geometry: one full line.
    rst = 1'b0;
    if_a.i_en = 1'b1;
    vde_n = 0; hs_n = 0; hs_first = -1; pos_err = 0;
    for (int i = 0; i < 2200; i++) begin
      tick();
      if (i == 0) begin
        check("a_first_vde",  if_a.o_vid_VDE, 1);
        check("a_first_sof",  if_a.o_sof, 1);
        check("a_first_data", if_a.o_vid_data, 24'hFFFFFF);
        check("a_first_pos",  {if_a.o_vcnt, if_a.o_hcnt}, 0);
      end
      if (if_a.o_hcnt != 12'(i) || if_a.o_vcnt != 11'd0) pos_err++;
      if (if_a.o_vid_VDE) vde_n++;
      if (if_a.o_vid_hsync) begin
        hs_n++;
        if (hs_first < 0) hs_first = int'(if_a.o_hcnt);
      end
      if (i == 239)  check("a_bar_239",  if_a.o_vid_data, 24'hFFFFFF);
      if (i == 240)  check("a_bar_240",  if_a.o_vid_data, 24'hFFFF00);
      if (i == 480)  check("a_bar_480",  if_a.o_vid_data, 24'h00FFFF);
      if (i == 1679) check("a_bar_1679", if_a.o_vid_data, 24'h0000FF);
      if (i == 1919) check("a_bar_1919", if_a.o_vid_data, 24'h000000);
      if (i == 1919) check("a_vde_1919", if_a.o_vid_VDE, 1);
      if (i == 1920) check("a_data_1920", if_a.o_vid_data, 0);
      if (i == 1920) check("a_vde_1920",  if_a.o_vid_VDE, 0);
    end
    check("a_pos_track", pos_err, 0);
    check("a_vde_count", vde_n, 1920);
    check("a_hs_count",  hs_n, 44);
    check("a_hs_first",  hs_first, 2008);
    tick();
    check("a_line1_pos",  {if_a.o_vcnt, if_a.o_hcnt}, {11'd1, 12'd0});
    check("a_line1_sof",  if_a.o_sof, 0);
    check("a_line1_data", if_a.o_vid_data, 24'hFFFFFF);
    if_a.i_en = 1'b0;
    tick();
    check("a_off_vde",  if_a.o_vid_VDE, 0);
    check("a_off_data", if_a.o_vid_data, 0);
    check("a_off_hcnt", if_a.o_hcnt, 0);

    // Reduced geometry: two full frames plus the next origin.
    if_b.i_en = 1'b1;
    vs_n = 0; vs_min = 9999; vs_max = -1; sof_n = 0; hs_first = -1;
    sof_idx[0] = -1; sof_idx[1] = -1; sof_idx[2] = -1;
    fc1 = 8'hxx; fc2 = 8'hxx;
    for (int i = 0; i <= 7680; i++) begin
      tick();
      if (if_b.o_sof) begin
        if (sof_n < 3) sof_idx[sof_n] = i;
        sof_n++;
      end
      if (if_b.o_vid_vsync) begin
        vs_n++;
        if (int'(if_b.o_vcnt) < vs_min) vs_min = int'(if_b.o_vcnt);
        if (int'(if_b.o_vcnt) > vs_max) vs_max = int'(if_b.o_vcnt);
      end
      if (if_b.o_vid_hsync && hs_first < 0) hs_first = int'(if_b.o_hcnt);
      if (i == 3840) fc1 = if_b.o_frame_cnt;
      if (i == 7680) fc2 = if_b.o_frame_cnt;
    end
    check("b_sof_count", sof_n, 3);
    check("b_sof_idx0",  sof_idx[0], 0);
    check("b_sof_idx1",  sof_idx[1], 3840);
    check("b_sof_idx2",  sof_idx[2], 7680);
    check("b_vs_count",  vs_n, 480);
    check("b_vs_min",    vs_min, 42);
    check("b_vs_max",    vs_max, 44);
    check("b_hs_first",  hs_first, 68);
    check("b_fc1",       fc1, 1);
    check("b_fc2",       fc2, 2);

    // Mode change mid-frame: rest of frame 2 stays bars.
    wait_b(0, 20);
    if_b.i_mode = 2'd2;
    err = 0;
    for (int n = 0; n < 4000; n++) begin
      tick();
      if (if_b.o_hcnt == 12'd0 && if_b.o_vcnt == 11'd0) break;
      if (if_b.o_vid_VDE && if_b.o_vid_data != bar_col(int'(if_b.o_hcnt) / 8)) err++;
    end
    check("b_latch_bars", err, 0);
    check("b_f3_origin_pos",  {if_b.o_vcnt, if_b.o_hcnt}, 0);
    check("b_f3_origin_data", if_b.o_vid_data, 24'h000000);
    wait_b(32, 0);
    check("b_chk_32_0", if_b.o_vid_data, 24'hFFFFFF);
    wait_b(0, 32);
    check("b_chk_0_32", if_b.o_vid_data, 24'hFFFFFF);
    wait_b(32, 32);
    check("b_chk_32_32", if_b.o_vid_data, 24'h000000);

    // Solid colour in frame 4; ramp selected for frame 5 during frame 4.
    if_b.i_mode = 2'd3;
    if_b.i_solid_rgb = 24'h123456;
    wait_b(0, 0);
    check("b_solid_origin", if_b.o_vid_data, 24'h123456);
    if_b.i_mode = 2'd1;
    if_b.i_solid_rgb = 24'hABCDEF;
    err = 0;
    for (int n = 1; n < 3840; n++) begin
      tick();
      if (if_b.o_vid_data != (if_b.o_vid_VDE ? 24'h123456 : 24'h000000)) err++;
    end
    check("b_solid_frame", err, 0);
    wait_b(5, 0);
    check("b_ramp_fc",   if_b.o_frame_cnt, 5);
    check("b_ramp_5_0",  if_b.o_vid_data, 24'h0A0A0A);

    // Enable drop mid-frame and restart.
    wait_b(10, 20);
    if_b.i_en = 1'b0;
    tick();
    check("b_drop_vde",  if_b.o_vid_VDE, 0);
    check("b_drop_data", if_b.o_vid_data, 0);
    check("b_drop_hs",   if_b.o_vid_hsync, 0);
    check("b_drop_sof",  if_b.o_sof, 0);
    check("b_drop_pos",  {if_b.o_vcnt, if_b.o_hcnt}, 0);
    repeat (3) tick();
    check("b_idle_sof",  if_b.o_sof, 0);
    if_b.i_en = 1'b1;
    tick();
    check("b_restart_sof",  if_b.o_sof, 1);
    check("b_restart_pos",  {if_b.o_vcnt, if_b.o_hcnt}, 0);
    check("b_restart_fc",   if_b.o_frame_cnt, 5);
    check("b_restart_data", if_b.o_vid_data, 24'h050505);

    // Active-low syncs: same positions, inverted levels.
    if_c.i_en = 1'b1;
    hs_n = 0; hs_first = -1; vs_n = 0; vs_min = 9999; vs_max = -1; vde_n = 0;
    for (int i = 0; i < 3840; i++) begin
      tick();
      if (i == 0) check("c_origin_hs", if_c.o_vid_hsync, 1);
      if (if_c.o_vid_VDE) vde_n++;
      if (!if_c.o_vid_hsync) begin
        hs_n++;
        if (hs_first < 0) hs_first = int'(if_c.o_hcnt);
      end
      if (!if_c.o_vid_vsync) begin
        vs_n++;
        if (int'(if_c.o_vcnt) < vs_min) vs_min = int'(if_c.o_vcnt);
        if (int'(if_c.o_vcnt) > vs_max) vs_max = int'(if_c.o_vcnt);
      end
    end
    check("c_vde_count", vde_n, 2560);
    check("c_hs_count",  hs_n, 192);
    check("c_hs_first",  hs_first, 68);
    check("c_vs_count",  vs_n, 240);
    check("c_vs_min",    vs_min, 42);
    check("c_vs_max",    vs_max, 44);
    if_c.i_en = 1'b0;

    // Tiny geometry: frame counter wraps 255 -> 0.
    if_d.i_en = 1'b1;
    err = 0;
    for (int i = 0; i <= 14080; i++) begin
      tick();
      if (if_d.o_frame_cnt != 8'((i / 55) % 256)) err++;
      if (i == 14025) check("d_fc_255", if_d.o_frame_cnt, 255);
      if (i == 14080) begin
        check("d_fc_wrap", if_d.o_frame_cnt, 0);
        check("d_wrap_sof", if_d.o_sof, 1);
      end
    end
    check("d_fc_track", err, 0);
    if_d.i_en = 1'b0;

    // Reset mid-frame takes priority over enable.
    wait_b(30, 10);
    rst = 1'b1;
    tick();
    check("b_mrst_vde",  if_b.o_vid_VDE, 0);
    check("b_mrst_data", if_b.o_vid_data, 0);
    check("b_mrst_pos",  {if_b.o_vcnt, if_b.o_hcnt}, 0);
    check("b_mrst_hs",   if_b.o_vid_hsync, 0);
    rst = 1'b0;
    tick();
    check("b_mrst_sof", if_b.o_sof, 1);
    check("b_mrst_fc",  if_b.o_frame_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/vid_timing_gen.md
Name: vid_timing_gen

Overview:
- Upstream source for the colour_change stage.
- Generates 1080p video timing (hsync, vsync, VDE) and a selectable 24-bit RGB test pattern from a single pixel clock.
- Produces exactly the i_vid_* bundle that colour_change consumes, plus position/frame status.
- Replaces file-driven stimulus on hardware and doubles as a stimulus source in simulation.

Parameters:
- H_ACTIVE, 1920, active pixels per line
- H_FP, 88, horizontal front porch (clocks)
- H_SYNC, 44, hsync width (clocks)
- H_BP, 148, horizontal back porch; H_TOTAL = sum of the four horizontal values = 2200
- V_ACTIVE, 1080, active lines per frame
- V_FP, 4, vertical front porch (lines)
- V_SYNC, 5, vsync width (lines)
- V_BP, 36, vertical back porch; V_TOTAL = 1125
- SYNC_POL, 1, 1 = sync pulses active-high, 0 = active-low
- BAR_W, 240, colour-bar width in pixels; H_ACTIVE must equal 8*BAR_W

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous reset, active-high
- i_en  in  1  generator enable
- i_mode  in  2  pattern select: 0 bars, 1 ramp, 2 checker, 3 solid
- i_solid_rgb  in  24  colour for mode 3, {R,G,B}
- o_vid_data  out  24  pixel {R[23:16],G[15:8],B[7:0]}
- o_vid_hsync  out  1  horizontal sync
- o_vid_vsync  out  1  vertical sync
- o_vid_VDE  out  1  active-video flag
- o_hcnt  out  12  horizontal position of the current output
- o_vcnt  out  11  vertical position of the current output
- o_frame_cnt  out  8  completed-frame count, wraps 255->0
- o_sof  out  1  one-cycle pulse on the first active pixel of each frame

Behaviour:
- Reset, synchronous on rst=1:
  - hcnt=0, vcnt=0, frame_cnt=0, latched mode=0.
  - All outputs are driven low, except the sync outputs, which go to their inactive level (~SYNC_POL).
- i_en=0: counters are held at 0,0 and outputs are driven to reset values. frame_cnt and latched mode are held.
  - The first cycle with i_en=1 processes position (0,0).
  - Dropping i_en mid-frame aborts the frame; no partial increment of frame_cnt.
- Counters, when enabled, step every clock:
  - hcnt runs 0..H_TOTAL-1.
  - When hcnt wraps, vcnt increments 0..V_TOTAL-1.
  - A simultaneous wrap of both counters returns to (0,0) and increments frame_cnt. frame_cnt wraps from 255 to 0.
- Timing decode, for position (h,v):
  - VDE = (h < H_ACTIVE) and (v < V_ACTIVE).
  - hsync active for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC, i.e. 2008..2051 at defaults.
  - vsync active for V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC, i.e. lines 1084..1088. vsync spans the whole of each of those lines.
- Latency and alignment:
  - All outputs are registered.
  - Every output in cycle n describes the position held by the counters in cycle n-1.
  - data, hsync, vsync, VDE, o_hcnt and o_vcnt are mutually aligned; no skew between them.
- Mode latch: i_mode and i_solid_rgb are sampled only when the counters are at (0,0). Mid-frame changes take effect on the next frame.
- Blanking: when VDE=0, o_vid_data = 0.
- Patterns (active pixels only):
  - Bars:
    - A bar index 0..7 advances every BAR_W active pixels and resets at h=0.
    - Bar index is kept with a counter; no divider.
    - Colours in order: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
  - Ramp: grey g = (h[7:0] + frame_cnt) mod 256, output {g,g,g}. Moves one step per frame.
  - Checker: (h[5] XOR v[5]) ? FFFFFF : 000000. 32x32 squares.
  - Solid: the latched i_solid_rgb.
- o_sof: high for exactly the one output cycle that carries position (0,0). Never asserted while i_en=0.
- Reset mid-frame: takes priority over i_en. Outputs are at reset values on the cycle after rst is sampled high.

Test Plan:
- Reset and enable: rst high 3 clocks, then i_en=1 → outputs at reset values during reset; the first enabled output cycle shows VDE=1, o_hcnt=0, o_vcnt=0, o_sof=1, data=FFFFFF (bars).
- Line timing: run one line at defaults, counting clocks → VDE high 1920 clocks, hsync high exactly 44 clocks starting at o_hcnt=2008, period 2200 clocks.
- Frame timing and wrap: run 2 full frames → vsync covers o_vcnt 1084..1088 (5*2200 clocks); o_frame_cnt goes 0→1→2; o_sof pulses once per 2,475,000 clocks. Force frame_cnt to 255 → wraps to 0.
- Bar boundaries: mode 0 → o_hcnt=239 gives FFFFFF, 240 gives FFFF00, 1919 gives 000000, 1920 gives data 0 with VDE=0.
- Mode latch: switch i_mode 0→2 at o_vcnt=500 → remainder of the frame stays bars; the next frame at (0,0) is black and (32,0) is white. Mode 3 with i_solid_rgb=123456 gives 123456 on every active pixel.
- Enable drop and SYNC_POL: i_en=0 mid-frame → outputs blank/inactive, restart at (0,0) with o_sof, frame_cnt unchanged. Repeat with SYNC_POL=0 → syncs idle high and pulse low with identical positions.
